simd_share_arb: RTL and testbench



---
 rtl/simd_share_arb.sv | 184 ++++++++++++++++++
 tb/tb_simd_share_arb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_share_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// simd_share_arb: round-robin, credit-gated sharing of one fixed-latency SIMD
// unit between two issue ports, with per-port in-order result FIFOs.
// Optional feature macro: SIMD_ARB_FLUSH_EN (adds the flush input).
// Revision: 1.0
// ----------------------------------------------------------------------------
module simd_share_arb #(
  parameter int LAT   = 2,
  parameter int DEPTH = 2,
  parameter int TAGW  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][12:0]     req_op,
  input  logic [1:0][67:0]     req_A,
  input  logic [1:0][67:0]     req_B,
  input  logic [1:0][TAGW-1:0] req_tag,
  output logic                 simd_en,
  output logic [12:0]          simd_op,
  output logic [67:0]          simd_A,
  output logic [67:0]          simd_B,
  input  logic [67:0]          simd_res,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [1:0][67:0]     rsp_data,
  output logic [1:0][TAGW-1:0] rsp_tag
`ifdef SIMD_ARB_FLUSH_EN
  ,
  input  logic                 flush
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic flush_w;
`ifdef SIMD_ARB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic [1:0] elig;
  logic       gnt_v;
  logic       gnt_p;
  logic       lg_q;
  logic       lg_d;

  logic [LAT-1:0]           pv_q;
  logic [LAT-1:0]           pp_q;
  logic [LAT-1:0][TAGW-1:0] pt_q;

  logic            ret_v;
  logic            ret_p;
  logic [TAGW-1:0] ret_tag;

  assign ret_v   = pv_q[LAT-1];
  assign ret_p   = pp_q[LAT-1];
  assign ret_tag = pt_q[LAT-1];

  // Grant is purely combinational; reset and flush both suppress it.
  always_comb begin
    gnt_v = 1'b0;
    gnt_p = 1'b0;
    if (!rst && !flush_w) begin
      if (elig[0] && elig[1]) begin
        gnt_v = 1'b1;
        gnt_p = ~lg_q;
      end else if (elig[0]) begin
        gnt_v = 1'b1;
        gnt_p = 1'b0;
      end else if (elig[1]) begin
        gnt_v = 1'b1;
        gnt_p = 1'b1;
      end
    end
    lg_d = gnt_v ? gnt_p : lg_q;
  end

  assign req_ready[0] = gnt_v && !gnt_p;
  assign req_ready[1] = gnt_v && gnt_p;
  assign simd_en      = gnt_v;
  assign simd_op      = gnt_v ? req_op[gnt_p] : 13'd0;
  assign simd_A       = gnt_v ? req_A[gnt_p]  : 68'd0;
  assign simd_B       = gnt_v ? req_B[gnt_p]  : 68'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lg_q <= 1'b1;
    end else begin
      lg_q <= lg_d;
    end
  end

  // Tag pipeline mirrors the unit's latency so the last stage lines up with simd_res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q <= '0;
      pp_q <= '0;
      pt_q <= '0;
    end else begin
      pv_q[0] <= gnt_v;
      pp_q[0] <= gnt_p;
      pt_q[0] <= req_tag[gnt_p];
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1] && !flush_w;
        pp_q[i] <= pp_q[i-1];
        pt_q[i] <= pt_q[i-1];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DEPTH-1:0][67:0]     dmem_q;
    logic [DEPTH-1:0][TAGW-1:0] tmem_q;
    logic [PW-1:0]              wp_q;
    logic [PW-1:0]              rp_q;
    logic [CW-1:0]              cnt_q;
    logic [CW-1:0]              cnt_d;
    logic [CW-1:0]              inf_q;
    logic [CW-1:0]              inf_d;
    logic                       push;
    logic                       pop;
    logic                       iss;
    logic                       ret;

    assign iss  = gnt_v && (gnt_p == 1'(p));
    assign ret  = ret_v && (ret_p == 1'(p));
    assign push = ret && !flush_w;
    assign pop  = rsp_ready[p] && (cnt_q != '0);

    // Credits are occupancy plus in-flight, sampled before this cycle's pop.
    assign elig[p] = req_valid[p] &&
                     (((CW+1)'(inf_q) + (CW+1)'(cnt_q)) < (CW+1)'(DEPTH));

    always_comb begin
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      inf_d = inf_q + CW'(iss) - CW'(ret);
      if (flush_w) begin
        cnt_d = '0;
        inf_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dmem_q <= '0;
        tmem_q <= '0;
        wp_q   <= '0;
        rp_q   <= '0;
        cnt_q  <= '0;
        inf_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        inf_q <= inf_d;
        if (flush_w) begin
          wp_q <= '0;
          rp_q <= '0;
        end else begin
          if (push) begin
            dmem_q[wp_q] <= simd_res;
            tmem_q[wp_q] <= ret_tag;
            wp_q         <= (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
          end
          if (pop) begin
            rp_q <= (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
          end
        end
      end
    end

    assign rsp_valid[p] = (cnt_q != '0);
    assign rsp_data[p]  = dmem_q[rp_q];
    assign rsp_tag[p]   = tmem_q[rp_q];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && (cnt_q == CW'(DEPTH))));
  end

endmodule
`default_nettype wire

// File: tb/tb_simd_share_arb.sv
`default_nettype none
// Bench for simd_share_arb: randomized traffic checked against a transaction-level
// model (per-port queues of issued-but-unpopped results with their visibility cycle).
module tb_simd_share_arb;
  localparam int LAT   = 2;
  localparam int DEPTH = 2;
  localparam int TAGW  = 9;
  localparam logic [12:0] OP_PADD = 13'h0001;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           req_valid = '0;
  logic [1:0]           req_ready;
  logic [1:0][12:0]     req_op = '0;
  logic [1:0][67:0]     req_A = '0;
  logic [1:0][67:0]     req_B = '0;
  logic [1:0][TAGW-1:0] req_tag = '0;
  logic                 simd_en;
  logic [12:0]          simd_op;
  logic [67:0]          simd_A;
  logic [67:0]          simd_B;
  logic [67:0]          simd_res = '0;
  logic [1:0]           rsp_valid;
  logic [1:0]           rsp_ready = '0;
  logic [1:0][67:0]     rsp_data;
  logic [1:0][TAGW-1:0] rsp_tag;
  logic                 flush = 1'b0;

  simd_share_arb #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_A(req_A), .req_B(req_B), .req_tag(req_tag),
    .simd_en(simd_en), .simd_op(simd_op), .simd_A(simd_A), .simd_B(simd_B),
    .simd_res(simd_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
`ifdef SIMD_ARB_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [67:0]     data;
    logic [TAGW-1:0] tag;
    int              rdy;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  logic [67:0] res_at [int];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  logic  m_lg = 1'b1;
  string tname = "init";

  logic [1:0][12:0]     s_op;
  logic [1:0][67:0]     s_A;
  logic [1:0][67:0]     s_B;
  logic [1:0][TAGW-1:0] s_tag;
  logic                 s_flush = 1'b0;
  logic [1:0]           last_ready;
  logic                 last_en;

  function automatic logic [67:0] r68();
    return {4'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [67:0] unit_fn(logic [12:0] op, logic [67:0] a, logic [67:0] b);
    return (op == OP_PADD) ? a + b : (a ^ b ^ {55'd0, op});
  endfunction

  function automatic int qs(int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ent_t qh(int p);
    return (p == 0) ? q0[0] : q1[0];
  endfunction

  // One clock cycle: drive at the falling edge, compare 1 ns later, then advance the model.
  task automatic run_cycle(input logic [1:0] rv, input logic [1:0] rr, input bit rnd);
    logic [1:0]  el;
    logic [1:0]  ev;
    logic        eg_v;
    logic        eg_p;
    logic [1:0]  e_ready;
    logic [12:0] e_op;
    logic [67:0] e_a;
    logic [67:0] e_b;
    ent_t        e;
    @(negedge clk);
    if (rnd) begin
      for (int p = 0; p < 2; p++) begin
        s_op[p]  = 13'($urandom);
        s_A[p]   = r68();
        s_B[p]   = r68();
        s_tag[p] = TAGW'($urandom);
      end
    end
    req_valid = rv;
    rsp_ready = rr;
    req_op    = s_op;
    req_A     = s_A;
    req_B     = s_B;
    req_tag   = s_tag;
    flush     = s_flush;
    simd_res  = res_at.exists(cyc) ? res_at[cyc] : r68();
    #1;
    for (int p = 0; p < 2; p++) begin
      el[p] = rv[p] && (qs(p) < DEPTH) && !s_flush;
      ev[p] = (qs(p) > 0) && (qh(p).rdy <= cyc);
    end
    eg_v = el[0] || el[1];
    eg_p = (el[0] && el[1]) ? ~m_lg : el[1];
    e_ready = {eg_v && eg_p, eg_v && !eg_p};
    e_op = eg_v ? s_op[eg_p] : 13'd0;
    e_a  = eg_v ? s_A[eg_p]  : 68'd0;
    e_b  = eg_v ? s_B[eg_p]  : 68'd0;
    last_ready = req_ready;
    last_en    = simd_en;
    checks++;
    if (req_ready !== e_ready) begin
      errors++;
      $display("FAIL %s req_ready cyc=%0d: got %b want %b", tname, cyc, req_ready, e_ready);
    end
    checks++;
    if (simd_en !== eg_v || simd_op !== e_op || simd_A !== e_a || simd_B !== e_b) begin
      errors++;
      $display("FAIL %s issue cyc=%0d: got en=%b op=%h A=%h B=%h want en=%b op=%h A=%h B=%h",
               tname, cyc, simd_en, simd_op, simd_A, simd_B, eg_v, e_op, e_a, e_b);
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (rsp_valid[p] !== ev[p]) begin
        errors++;
        $display("FAIL %s rsp_valid[%0d] cyc=%0d: got %b want %b", tname, p, cyc, rsp_valid[p], ev[p]);
      end else if (ev[p]) begin
        e = qh(p);
        checks++;
        if (rsp_data[p] !== e.data || rsp_tag[p] !== e.tag) begin
          errors++;
          $display("FAIL %s rsp[%0d] cyc=%0d: got data=%h tag=%h want data=%h tag=%h",
                   tname, p, cyc, rsp_data[p], rsp_tag[p], e.data, e.tag);
        end
      end
    end
    if (rr[0] && ev[0]) void'(q0.pop_front());
    if (rr[1] && ev[1]) void'(q1.pop_front());
    if (s_flush) begin
      q0.delete();
      q1.delete();
    end
    if (eg_v) begin
      e.data = unit_fn(s_op[eg_p], s_A[eg_p], s_B[eg_p]);
      e.tag  = s_tag[eg_p];
      e.rdy  = cyc + LAT + 1;
      if (eg_p) q1.push_back(e);
      else      q0.push_back(e);
      res_at[cyc + LAT] = e.data;
      m_lg = eg_p;
    end
    cyc++;
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    res_at.delete();
    m_lg = 1'b1;
  endtask

  // Asserts reset at a falling edge, releases it just after the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    clear_model();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00 || simd_en !== 1'b0 || simd_op !== 13'd0 ||
        simd_A !== 68'd0 || simd_B !== 68'd0 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL %s during_rst: got ready=%b en=%b op=%h rsp_valid=%b want all zero",
               tname, req_ready, simd_en, simd_op, rsp_valid);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    run_cycle(2'b00, 2'b11, 1);
    checks++;
    if (last_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL %s after_release: got ready=%b rsp_valid=%b want 00 00", tname, last_ready, rsp_valid);
    end
  endtask

  task automatic test_single_op();
    tname = "single_op";
    do_reset();
    for (int k = 0; k < 6; k++) begin
      s_op  = '0; s_A = '0; s_B = '0; s_tag = '0;
      if (k == 0) begin
        s_op[0]  = OP_PADD;
        s_A[0]   = 68'h0_0000_0000_0000_00A0;
        s_B[0]   = 68'h0_0000_0000_0000_000A;
        s_tag[0] = 9'h005;
      end
      run_cycle((k == 0) ? 2'b01 : 2'b00, (k == 3) ? 2'b01 : 2'b00, 0);
      checks++;
      if (last_en !== (k == 0)) begin
        errors++;
        $display("FAIL %s simd_en k=%0d: got %b want %b", tname, k, last_en, (k == 0));
      end
      if (k == 3) begin
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 68'hAA || rsp_tag[0] !== 9'h005) begin
          errors++;
          $display("FAIL %s response: got v=%b data=%h tag=%h want v=1 data=aa tag=005",
                   tname, rsp_valid[0], rsp_data[0], rsp_tag[0]);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    tname = "contention";
    do_reset();
    for (int k = 0; k < 10; k++) begin
      run_cycle(2'b11, 2'b11, 1);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (last_ready !== want) begin
        errors++;
        $display("FAIL %s alternate k=%0d: got %b want %b", tname, k, last_ready, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    tname = "back_to_back";
    for (int k = 0; k < 8; k++) begin
      run_cycle(2'b11, 2'b11, 1);
      checks++;
      if (last_en !== 1'b1) begin
        errors++;
        $display("FAIL %s every_cycle k=%0d: got en=%b want 1", tname, k, last_en);
      end
    end
    for (int k = 0; k < 5; k++) run_cycle(2'b00, 2'b11, 1);
  endtask

  task automatic test_credit_stall();
    int grants;
    tname = "credit_stall";
    do_reset();
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      run_cycle(2'b01, 2'b00, 1);
      if (last_ready[0]) grants++;
    end
    checks++;
    if (grants !== 2) begin
      errors++;
      $display("FAIL %s grants: got %0d want 2", tname, grants);
    end
    run_cycle(2'b01, 2'b01, 1);
    checks++;
    if (last_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL %s pop_cycle: got ready=%b want 0", tname, last_ready[0]);
    end
    run_cycle(2'b01, 2'b00, 1);
    checks++;
    if (last_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s after_pop: got ready=%b want 1", tname, last_ready[0]);
    end
    for (int k = 0; k < 6; k++) run_cycle(2'b00, 2'b11, 1);
  endtask

  task automatic test_same_cycle();
    logic [TAGW-1:0] t1;
    tname = "same_cycle";
    do_reset();
    run_cycle(2'b10, 2'b00, 1);
    run_cycle(2'b10, 2'b00, 1);
    t1 = s_tag[1];
    run_cycle(2'b00, 2'b00, 1);
    run_cycle(2'b00, 2'b10, 1);
    run_cycle(2'b00, 2'b00, 1);
    checks++;
    if (rsp_valid[1] !== 1'b1 || rsp_tag[1] !== t1) begin
      errors++;
      $display("FAIL %s second_head: got v=%b tag=%h want v=1 tag=%h", tname, rsp_valid[1], rsp_tag[1], t1);
    end
    run_cycle(2'b00, 2'b10, 1);
    run_cycle(2'b00, 2'b00, 1);
    checks++;
    if (rsp_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL %s drained: got v=%b want 0", tname, rsp_valid[1]);
    end
  endtask

  task automatic test_random();
    tname = "random";
    for (int k = 0; k < 400; k++) begin
      run_cycle(2'($urandom), 2'($urandom), 1);
    end
    for (int k = 0; k < 6; k++) run_cycle(2'b00, 2'b11, 1);
  endtask

  task automatic test_reset_midflight();
    tname = "reset_midflight";
    run_cycle(2'b01, 2'b00, 1);
    run_cycle(2'b10, 2'b00, 1);
    run_cycle(2'b01, 2'b00, 1);
    run_cycle(2'b10, 2'b00, 1);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || simd_en !== 1'b0 || simd_op !== 13'd0) begin
      errors++;
      $display("FAIL %s in_rst: got rsp_valid=%b ready=%b en=%b op=%h want zeros",
               tname, rsp_valid, req_ready, simd_en, simd_op);
    end
    clear_model();
    @(posedge clk);
    #2;
    rst = 1'b0;
    run_cycle(2'b01, 2'b00, 1);
    checks++;
    if (last_ready !== 2'b01) begin
      errors++;
      $display("FAIL %s first_grant: got %b want 01", tname, last_ready);
    end
    for (int k = 0; k < 6; k++) run_cycle(2'b00, 2'b11, 1);
  endtask

`ifdef SIMD_ARB_FLUSH_EN
  task automatic test_flush();
    tname = "flush";
    do_reset();
    run_cycle(2'b01, 2'b00, 1);
    run_cycle(2'b10, 2'b00, 1);
    s_flush = 1'b1;
    run_cycle(2'b11, 2'b11, 1);
    s_flush = 1'b0;
    checks++;
    if (last_ready !== 2'b00 || last_en !== 1'b0) begin
      errors++;
      $display("FAIL %s suppressed: got ready=%b en=%b want 00 0", tname, last_ready, last_en);
    end
    run_cycle(2'b01, 2'b00, 1);
    checks++;
    if (last_ready !== 2'b01) begin
      errors++;
      $display("FAIL %s resume: got %b want 01", tname, last_ready);
    end
    run_cycle(2'b00, 2'b00, 1);
    run_cycle(2'b00, 2'b00, 1);
    run_cycle(2'b00, 2'b01, 1);
    checks++;
    if (rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL %s post_resp: got %b want 01", tname, rsp_valid);
    end
    for (int k = 0; k < 4; k++) run_cycle(2'b00, 2'b11, 1);
  endtask
`endif

  initial begin
    s_op = '0; s_A = '0; s_B = '0; s_tag = '0;
    test_reset();
    test_single_op();
    test_contention();
    test_back_to_back();
    test_credit_stall();
    test_same_cycle();
    test_random();
    test_reset_midflight();
`ifdef SIMD_ARB_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
